road_request_arbiter: RTL and testbench

- Generates the one-hot Emergency, Jam and Empty request vectors that drive the four-road traffic light controller.
- Inputs are raw per-road vehicle-presence sensors and emergency-vehicle detectors.
- Debounces and times presence into jam and empty conditions.
- Arbitrates competing emergency and jam requests round-robin and holds each grant for a programmable number of ticks, so the light controller never sees more than one road requested at once.

---
 rtl/road_pkg.sv | 41 ++++
 rtl/road_occupancy_monitor.sv | 45 ++++
 rtl/road_request_arbiter.sv | 137 +++++++++++++
 tb/tb_road_request_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_pkg.sv
// Shared road constants, arbiter FSM states and round-robin helpers.
// Bit order everywhere: [3]=east [2]=north [1]=west [0]=south.
package road_pkg;

  localparam int EAST  = 3;
  localparam int NORTH = 2;
  localparam int WEST  = 1;
  localparam int SOUTH = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMERG,
    S_JAM
  } state_t;

  // Search order is east, north, west, south, starting one after ptr.
  // That is a descending index walk, so ptr-1 is tried first.
  // The loop walks backwards so the earliest candidate overwrites last.
  function automatic logic [3:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr - 2'(k);
      if (req[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/road_occupancy_monitor.sv
// Per-road presence/absence timer producing jam and empty flags.
// Ports: clk, rst, tick, present, clear_pres -> jam_flag, empty_flag.
module road_occupancy_monitor #(
  parameter int unsigned JAM_TICKS   = 8,
  parameter int unsigned EMPTY_TICKS = 4,
  parameter int unsigned CW          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic present,
  input  logic clear_pres,
  output logic jam_flag,
  output logic empty_flag
);

  localparam logic [CW-1:0] JT = CW'(JAM_TICKS);
  localparam logic [CW-1:0] ET = CW'(EMPTY_TICKS);

  logic [CW-1:0] pres_cnt;
  logic [CW-1:0] abs_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pres_cnt <= '0;
      abs_cnt  <= '0;
    end else begin
      if (tick) begin
        if (present) begin
          if (pres_cnt != JT) pres_cnt <= pres_cnt + 1'b1;
          abs_cnt <= '0;
        end else begin
          if (abs_cnt != ET) abs_cnt <= abs_cnt + 1'b1;
          pres_cnt <= '0;
        end
      end
      // A jam grant restarts qualification even if a tick lands too.
      if (clear_pres) pres_cnt <= '0;
    end
  end

  assign jam_flag   = (pres_cnt == JT);
  assign empty_flag = (abs_cnt == ET);

endmodule

// File: rtl/road_request_arbiter.sv
// Builds one-hot Emergency/Jam/Empty requests for the light controller.
// Ports: clk, rst, tick, veh_present[4], emerg_req[4] -> Emergency,
// Jam, Empty (each onehot0), busy (a grant is being held).
module road_request_arbiter #(
  parameter int unsigned JAM_TICKS   = 8,
  parameter int unsigned EMPTY_TICKS = 4,
  parameter int unsigned EMERG_HOLD  = 6,
  parameter int unsigned JAM_HOLD    = 10,
  parameter int unsigned CW          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] veh_present,
  input  logic [3:0] emerg_req,
  output logic [3:0] Emergency,
  output logic [3:0] Jam,
  output logic [3:0] Empty,
  output logic       busy
);

  import road_pkg::*;

  state_t        state, state_n;
  logic [CW-1:0] hold, hold_n;
  logic [3:0]    emerg_n, jam_n, empty_n;
  logic [3:0]    emerg_q, pend_e, pend_n;
  logic [1:0]    eptr, eptr_n, jptr, jptr_n;
  logic [3:0]    jam_flag, empty_flag;
  logic [3:0]    egnt, jgnt;

  for (genvar i = 0; i < 4; i++) begin : g_road
    road_occupancy_monitor #(
      .JAM_TICKS  (JAM_TICKS),
      .EMPTY_TICKS(EMPTY_TICKS),
      .CW         (CW)
    ) u_mon (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .present   (veh_present[i]),
      .clear_pres(jgnt[i]),
      .jam_flag  (jam_flag[i]),
      .empty_flag(empty_flag[i])
    );
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    emerg_n = Emergency;
    jam_n   = Jam;
    empty_n = '0;
    eptr_n  = eptr;
    jptr_n  = jptr;
    egnt    = '0;
    jgnt    = '0;
    unique case (state)
      S_IDLE: begin
        if (|pend_e)
          egnt = rr_pick(pend_e, eptr);
        else if (|jam_flag)
          jgnt = rr_pick(jam_flag, jptr);
        else begin
          priority case (1'b1)
            empty_flag[EAST]:  empty_n[EAST]  = 1'b1;
            empty_flag[NORTH]: empty_n[NORTH] = 1'b1;
            empty_flag[WEST]:  empty_n[WEST]  = 1'b1;
            empty_flag[SOUTH]: empty_n[SOUTH] = 1'b1;
            default: ;
          endcase
        end
      end
      S_EMERG, S_JAM: begin
        // Emergencies preempt a jam hold but never another emergency.
        if (state == S_JAM && |pend_e)
          egnt = rr_pick(pend_e, eptr);
        else if (tick) begin
          if (hold == CW'(1)) begin
            state_n = S_IDLE;
            emerg_n = '0;
            jam_n   = '0;
          end else begin
            hold_n = hold - 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        emerg_n = '0;
        jam_n   = '0;
      end
    endcase
    if (|egnt) begin
      state_n = S_EMERG;
      hold_n  = CW'(EMERG_HOLD);
      emerg_n = egnt;
      jam_n   = '0;
      eptr_n  = oh_idx(egnt);
    end
    if (|jgnt) begin
      state_n = S_JAM;
      hold_n  = CW'(JAM_HOLD);
      jam_n   = jgnt;
      jptr_n  = oh_idx(jgnt);
    end
    // A grant consumes an edge arriving on its own road this cycle.
    pend_n = (pend_e | (emerg_req & ~emerg_q)) & ~egnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      Emergency <= '0;
      Jam       <= '0;
      Empty     <= '0;
      emerg_q   <= '0;
      pend_e    <= '0;
      eptr      <= 2'(SOUTH);
      jptr      <= 2'(SOUTH);
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      Emergency <= emerg_n;
      Jam       <= jam_n;
      Empty     <= empty_n;
      emerg_q   <= emerg_req;
      pend_e    <= pend_n;
      eptr      <= eptr_n;
      jptr      <= jptr_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_road_request_arbiter.sv
// Scoreboard bench for road_request_arbiter: directed plan + random.
// A reference model pushes expected outputs; a monitor pops and checks.
module tb_road_request_arbiter;

  localparam int JT = 8;
  localparam int ET = 4;
  localparam int EH = 6;
  localparam int JH = 10;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] veh;
  logic [3:0] er;
  logic [3:0] Emergency;
  logic [3:0] Jam;
  logic [3:0] Empty;
  logic       busy;

  road_request_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .veh_present(veh),
    .emerg_req  (er),
    .Emergency  (Emergency),
    .Jam        (Jam),
    .Empty      (Empty),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] e;
    logic [3:0] j;
    logic [3:0] m;
    logic       b;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // Reference model: road-level bookkeeping in plain ints.
  int pc[4], ac[4];
  bit pend[4], prev_er[4];
  int mode;      // 0 idle, 1 emergency, 2 jam
  int hold_left;
  int eptr, jptr;
  int m_e, m_j, m_m;

  function automatic int pick(bit req[4], int ptr);
    for (int k = 1; k <= 4; k++) begin
      int r;
      r = (ptr + 4 - k) % 4;
      if (req[r]) return r;
    end
    return -1;
  endfunction

  function automatic logic [3:0] vec(int road);
    logic [3:0] v;
    v = '0;
    if (road >= 0) v[road] = 1'b1;
    return v;
  endfunction

  task automatic model_step(bit r, bit t, logic [3:0] v, logic [3:0] e);
    bit rise[4], jf[4], ef[4];
    bit anyp, anyj;
    int g, clr, ge;
    exp_t x;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        pc[i] = 0; ac[i] = 0; pend[i] = 0; prev_er[i] = 0;
      end
      mode = 0; hold_left = 0; eptr = 0; jptr = 0;
      m_e = -1; m_j = -1; m_m = -1;
    end else begin
      anyp = 0; anyj = 0; clr = -1; ge = -1;
      for (int i = 0; i < 4; i++) begin
        rise[i] = e[i] && !prev_er[i];
        prev_er[i] = e[i];
        jf[i] = (pc[i] == JT);
        ef[i] = (ac[i] == ET);
        anyp |= pend[i];
        anyj |= jf[i];
      end
      m_m = -1;
      if (mode != 1 && anyp) begin
        g = pick(pend, eptr);
        eptr = g; ge = g; mode = 1; hold_left = EH;
        m_e = g; m_j = -1;
      end else if (mode == 0 && anyj) begin
        g = pick(jf, jptr);
        jptr = g; clr = g; mode = 2; hold_left = JH;
        m_j = g; m_e = -1;
      end else if (mode == 0) begin
        m_e = -1; m_j = -1;
        for (int i = 3; i >= 0; i--)
          if (ef[i] && m_m < 0) m_m = i;
      end else if (t) begin
        if (hold_left == 1) begin
          mode = 0; m_e = -1; m_j = -1;
        end else hold_left--;
      end
      for (int i = 0; i < 4; i++) begin
        if (t) begin
          if (v[i]) begin
            pc[i] = (pc[i] + 1 > JT) ? JT : pc[i] + 1;
            ac[i] = 0;
          end else begin
            ac[i] = (ac[i] + 1 > ET) ? ET : ac[i] + 1;
            pc[i] = 0;
          end
        end
        pend[i] = pend[i] | rise[i];
      end
      if (clr >= 0) pc[clr] = 0;
      if (ge >= 0) pend[ge] = 0;
    end
    x.e = vec(m_e);
    x.j = vec(m_j);
    x.m = vec(m_m);
    x.b = (mode != 0);
    q.push_back(x);
  endtask

  // Monitor: every edge the DUT presents a new output set.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mx = q.pop_front();
      chk("Emergency", Emergency, mx.e);
      chk("Jam", Jam, mx.j);
      chk("Empty", Empty, mx.m);
      chk("busy", {3'b0, busy}, {3'b0, mx.b});
      chk("onehot0",
          {3'b0, $onehot0(Emergency) && $onehot0(Jam) && $onehot0(Empty)},
          4'd1);
      chk("exclusive",
          {3'b0, ((Emergency != 0) + (Jam != 0) + (Empty != 0)) <= 1},
          4'd1);
    end
  end

  task automatic cyc(bit r, bit t, logic [3:0] v, logic [3:0] e);
    @(negedge clk);
    rst = r; tick = t; veh = v; er = e;
    model_step(r, t, v, e);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] rot[5];
  logic [3:0] vr, ev;

  initial begin
    rst = 1'b1; tick = 1'b0; veh = '0; er = '0;
    rot[0] = 4'b1000; rot[1] = 4'b0100; rot[2] = 4'b0010;
    rot[3] = 4'b0001; rot[4] = 4'b1000;

    cyc(1, 0, 4'b0000, 4'b0000);
    cyc(1, 0, 4'b0000, 4'b0000);
    peek();
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_emerg", Emergency, 4'b0000);

    // All roads absent: east wins the empty indication.
    repeat (4) cyc(0, 1, 4'b0000, 4'b0000);
    cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("empty_east", Empty, 4'b1000);
    chk("empty_busy", {3'b0, busy}, 4'd0);

    // North jam and its 10-tick hold.
    repeat (8) cyc(0, 1, 4'b0100, 4'b0000);
    cyc(0, 0, 4'b0100, 4'b0000);
    peek();
    chk("jam_north", Jam, 4'b0100);
    chk("jam_noempty", Empty, 4'b0000);
    repeat (9) cyc(0, 1, 4'b0100, 4'b0000);
    peek();
    chk("jam_hold9", Jam, 4'b0100);
    cyc(0, 1, 4'b0000, 4'b0000);
    peek();
    chk("jam_release", Jam, 4'b0000);

    // Simultaneous west+south emergencies, west first.
    cyc(0, 0, 4'b0000, 4'b0011);
    cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("emerg_west", Emergency, 4'b0010);
    repeat (5) cyc(0, 1, 4'b0000, 4'b0000);
    peek();
    chk("emerg_hold5", Emergency, 4'b0010);
    cyc(0, 1, 4'b0000, 4'b0000);
    peek();
    chk("emerg_drop", Emergency, 4'b0000);
    cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("emerg_south", Emergency, 4'b0001);
    repeat (6) cyc(0, 1, 4'b0000, 4'b0000);
    cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("emerg_done", {3'b0, busy}, 4'd0);

    // Jam aborted by an east emergency.
    repeat (8) cyc(0, 1, 4'b0100, 4'b0000);
    cyc(0, 0, 4'b0100, 4'b0000);
    repeat (3) cyc(0, 1, 4'b0100, 4'b0000);
    cyc(0, 0, 4'b0100, 4'b1000);
    cyc(0, 0, 4'b0100, 4'b0000);
    peek();
    chk("abort_jam", Jam, 4'b0000);
    chk("abort_emerg", Emergency, 4'b1000);
    repeat (6) cyc(0, 1, 4'b0000, 4'b0000);
    cyc(0, 0, 4'b0000, 4'b0000);

    // Reset during an emergency grant with a pending north edge.
    cyc(0, 0, 4'b0000, 4'b1000);
    cyc(0, 0, 4'b0000, 4'b0000);
    cyc(0, 1, 4'b0000, 4'b0100);
    cyc(0, 1, 4'b0000, 4'b0000);
    cyc(1, 1, 4'b0000, 4'b0000);
    peek();
    chk("rstmid_emerg", Emergency, 4'b0000);
    chk("rstmid_busy", {3'b0, busy}, 4'd0);
    repeat (3) cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("pend_lost", Emergency, 4'b0000);
    cyc(0, 0, 4'b0000, 4'b1000);
    cyc(0, 0, 4'b0000, 4'b0000);
    peek();
    chk("east_after_rst", Emergency, 4'b1000);
    repeat (6) cyc(0, 1, 4'b0000, 4'b0000);

    // All four roads jammed: grants rotate.
    repeat (8) cyc(0, 1, 4'b1111, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 4'b1111, 4'b0000);
      peek();
      chk($sformatf("rot%0d", k), Jam, rot[k]);
      repeat (10) cyc(0, 1, 4'b1111, 4'b0000);
    end

    // Random traffic against the model.
    vr = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 15) == 0) vr[i] = ~vr[i];
        ev[i] = ($urandom_range(0, 19) == 0);
      end
      cyc($urandom_range(0, 599) == 0, 1'($urandom_range(0, 1)), vr, ev);
    end

    repeat (3) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d left expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
